// File: rtl/pwm_fade_ctrl.sv
// Breathing-fade duty sequencer for a PWM stage: ramps duty 0 -> max_value -> 0
// in prescaled steps, with programmable holds at both ends and a one-shot mode.
module pwm_fade_ctrl #(
  parameter int unsigned bit_width  = 8,
  parameter int unsigned div_width  = 16,
  parameter int unsigned hold_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  one_shot,
  input  logic [div_width-1:0]  step_div,
  input  logic [bit_width-1:0]  step_size,
  input  logic [bit_width-1:0]  max_value,
  input  logic [hold_width-1:0] hold_steps,
  output logic [bit_width-1:0]  duty,
  output logic [2:0]            phase,
  output logic                  cycle_done
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_UP       = 3'd1,
    ST_HOLD_TOP = 3'd2,
    ST_DOWN     = 3'd3,
    ST_HOLD_BOT = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [bit_width-1:0]  duty_q, duty_d;
  logic [div_width-1:0]  presc_q, presc_d;
  logic [hold_width-1:0] hold_cnt_q, hold_cnt_d;
  logic                  cycle_done_q, cycle_done_d;
  logic                  done_q, done_d;

  logic                  tick_s;
  logic [bit_width-1:0]  step_eff_s;
  logic [bit_width:0]    sum_s;

  // Step tick, effective step size and the widened ramp-up sum.
  always_comb begin
    step_eff_s = (step_size == {bit_width{1'b0}}) ? {{(bit_width-1){1'b0}}, 1'b1} : step_size;
    sum_s      = {1'b0, duty_q} + {1'b0, step_eff_s};
    // >= keeps the prescaler from running away if step_div shrinks below the count
    tick_s     = (state_q != ST_IDLE) && (presc_q >= step_div);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    presc_d      = presc_q;
    hold_cnt_d   = hold_cnt_q;
    cycle_done_d = 1'b0;
    done_d       = done_q;

    if (!enable) begin
      state_d    = ST_IDLE;
      duty_d     = {bit_width{1'b0}};
      presc_d    = {div_width{1'b0}};
      hold_cnt_d = {hold_width{1'b0}};
      done_d     = 1'b0;
    end else if (state_q == ST_IDLE) begin
      duty_d     = {bit_width{1'b0}};
      presc_d    = {div_width{1'b0}};
      hold_cnt_d = {hold_width{1'b0}};
      // A finished one-shot parks here until enable is dropped and raised again
      if (!done_q) begin
        state_d = ST_UP;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      if (tick_s) begin
        presc_d = {div_width{1'b0}};
      end else begin
        presc_d = presc_q + {{(div_width-1){1'b0}}, 1'b1};
      end

      if (duty_q > max_value) begin
        duty_d = max_value;
        if (state_q == ST_UP) begin
          state_d    = ST_HOLD_TOP;
          hold_cnt_d = {hold_width{1'b0}};
        end else begin
          state_d = state_q;
        end
      end else if (tick_s) begin
        case (state_q)
          ST_UP: begin
            if (sum_s >= {1'b0, max_value}) begin
              duty_d     = max_value;
              state_d    = ST_HOLD_TOP;
              hold_cnt_d = {hold_width{1'b0}};
            end else begin
              duty_d = sum_s[bit_width-1:0];
            end
          end
          ST_HOLD_TOP: begin
            if (hold_cnt_q >= hold_steps) begin
              state_d    = ST_DOWN;
              hold_cnt_d = {hold_width{1'b0}};
            end else begin
              hold_cnt_d = hold_cnt_q + {{(hold_width-1){1'b0}}, 1'b1};
            end
          end
          ST_DOWN: begin
            if (duty_q <= step_eff_s) begin
              duty_d     = {bit_width{1'b0}};
              state_d    = ST_HOLD_BOT;
              hold_cnt_d = {hold_width{1'b0}};
            end else begin
              duty_d = duty_q - step_eff_s;
            end
          end
          ST_HOLD_BOT: begin
            if (hold_cnt_q >= hold_steps) begin
              cycle_done_d = 1'b1;
              hold_cnt_d   = {hold_width{1'b0}};
              if (one_shot) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_UP;
              end
            end else begin
              hold_cnt_d = hold_cnt_q + {{(hold_width-1){1'b0}}, 1'b1};
            end
          end
          default: begin
            state_d    = ST_IDLE;
            duty_d     = {bit_width{1'b0}};
            hold_cnt_d = {hold_width{1'b0}};
          end
        endcase
      end else begin
        state_d = state_q;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      duty_q       <= {bit_width{1'b0}};
      presc_q      <= {div_width{1'b0}};
      hold_cnt_q   <= {hold_width{1'b0}};
      cycle_done_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      presc_q      <= presc_d;
      hold_cnt_q   <= hold_cnt_d;
      cycle_done_q <= cycle_done_d;
      done_q       <= done_d;
    end
  end

  assign duty       = duty_q;
  assign phase      = state_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: expected output-change events are queued
// with the stimulus and matched (values and cycle spacing) as the DUT changes.
module tb_pwm_fade_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        one_shot;
  logic [15:0] step_div;
  logic [7:0]  step_size;
  logic [7:0]  max_value;
  logic [7:0]  hold_steps;
  logic [7:0]  duty;
  logic [2:0]  phase;
  logic        cycle_done;

  pwm_fade_ctrl #(.bit_width(8), .div_width(16), .hold_width(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .one_shot  (one_shot),
    .step_div  (step_div),
    .step_size (step_size),
    .max_value (max_value),
    .hold_steps(hold_steps),
    .duty      (duty),
    .phase     (phase),
    .cycle_done(cycle_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    duty;
    int    phase;
    int    cd;
    int    gap;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  e;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic mon_en   = 1'b0;
  logic [11:0] obs;
  logic [11:0] prev_obs;
  int   gap_cnt;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int d, input int p, input int c, input int g);
    ev_t x;
    x.tag = tag; x.duty = d; x.phase = p; x.cd = c; x.gap = g;
    exp_q.push_back(x);
  endtask

  // One full up/hold/down cycle with step_div=3, step=64, max=255, hold=1.
  task automatic push_ramp(input string t);
    push({t, "_up0"},   0,   1, 0, -1);
    push({t, "_up64"},  64,  1, 0, 4);
    push({t, "_up128"}, 128, 1, 0, 4);
    push({t, "_up192"}, 192, 1, 0, 4);
    push({t, "_top"},   255, 2, 0, 4);
    push({t, "_down"},  255, 3, 0, 8);
    push({t, "_dn191"}, 191, 3, 0, 4);
    push({t, "_dn127"}, 127, 3, 0, 4);
    push({t, "_dn63"},  63,  3, 0, 4);
    push({t, "_bot"},   0,   4, 0, 4);
  endtask

  task automatic cfg(input int sd, input int ss, input int mx, input int hs, input logic os);
    step_div   = 16'(sd);
    step_size  = 8'(ss);
    max_value  = 8'(mx);
    hold_steps = 8'(hs);
    one_shot   = os;
  endtask

  task automatic start();
    @(negedge clk);
    mon_en = 1'b1;
    enable = 1'b1;
  endtask

  task automatic stop();
    mon_en = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_duty(input int val, input int budget);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (int'(duty) != val && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("wait_duty", duty, val);
  endtask

  // Monitor: every change of {duty, phase, cycle_done} must match the queue head.
  always @(negedge clk) begin
    obs = {duty, phase, cycle_done};
    if (!mon_en) begin
      prev_obs = obs;
      gap_cnt  = 0;
    end else begin
      gap_cnt++;
      if (obs != prev_obs) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_event", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_eq({e.tag, "_duty"}, duty, e.duty);
          check_eq({e.tag, "_phase"}, phase, e.phase);
          check_eq({e.tag, "_cd"}, cycle_done, e.cd);
          if (e.gap >= 0) check_eq({e.tag, "_gap"}, gap_cnt, e.gap);
        end
        prev_obs = obs;
        gap_cnt  = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    cfg(0, 0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("rst_duty", duty, 0);
    check_eq("rst_phase", phase, 0);
    check_eq("rst_cd", cycle_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Continuous ramp, into the second cycle
    cfg(3, 64, 255, 1, 1'b0);
    push_ramp("ramp");
    push("ramp_cd",     0,  1, 1, 8);
    push("ramp_cdfall", 0,  1, 0, 1);
    push("ramp_up2",    64, 1, 0, 3);
    start();
    drain(300);
    stop();

    // One-shot: parks in IDLE
    cfg(3, 64, 255, 1, 1'b1);
    push_ramp("os");
    push("os_cd",     0, 0, 1, 8);
    push("os_cdfall", 0, 0, 0, 1);
    start();
    drain(300);
    repeat (100) @(negedge clk);
    check_eq("os_idle_phase", phase, 0);
    check_eq("os_idle_duty", duty, 0);
    stop();

    // step_size=0 acts as 1, tick every clock
    cfg(0, 0, 3, 0, 1'b0);
    push("e0_up0", 0, 1, 0, -1);
    push("e0_up1", 1, 1, 0, 1);
    push("e0_up2", 2, 1, 0, 1);
    push("e0_top", 3, 2, 0, 1);
    start();
    drain(50);
    stop();

    // Step larger than ceiling
    cfg(3, 200, 150, 0, 1'b0);
    push("big_up0",  0,   1, 0, -1);
    push("big_top",  150, 2, 0, 4);
    push("big_down", 150, 3, 0, 4);
    push("big_bot",  0,   4, 0, 4);
    start();
    drain(100);
    stop();

    // Dynamic clamp in UP
    cfg(3, 64, 255, 1, 1'b0);
    push("cl_up0",   0,   1, 0, -1);
    push("cl_up64",  64,  1, 0, 4);
    push("cl_up128", 128, 1, 0, 4);
    push("cl_up192", 192, 1, 0, 4);
    push("cl_clamp", 100, 2, 0, 1);
    start();
    wait_duty(192, 100);
    max_value = 8'd100;
    drain(50);
    stop();

    // Abort during DOWN, then restart
    cfg(3, 64, 255, 1, 1'b0);
    push("ab_up0",   0,   1, 0, -1);
    push("ab_up64",  64,  1, 0, 4);
    push("ab_up128", 128, 1, 0, 4);
    push("ab_up192", 192, 1, 0, 4);
    push("ab_top",   255, 2, 0, 4);
    push("ab_down",  255, 3, 0, 8);
    push("ab_dn191", 191, 3, 0, 4);
    push("ab_dn127", 127, 3, 0, 4);
    push("ab_idle",  0,   0, 0, 1);
    start();
    wait_duty(127, 200);
    enable = 1'b0;
    drain(20);
    push("re_up0",   0,   1, 0, -1);
    push("re_up64",  64,  1, 0, 4);
    push("re_up128", 128, 1, 0, 4);
    @(negedge clk);
    enable = 1'b1;
    drain(100);
    stop();

    // Asynchronous reset mid-ramp
    cfg(3, 64, 255, 1, 1'b0);
    @(negedge clk);
    enable = 1'b1;
    wait_duty(128, 100);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_duty", duty, 0);
    check_eq("arst_phase", phase, 0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
